// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side byte packer: data width default,
// packer state encoding and the lane keep-mask helper.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int MAX_LANES  = 8;
  localparam int MASK_CNT_W = 4;

  typedef enum logic [1:0] {FILL, DRAIN, OUT} pack_state_t;

  // Thermometer mask with the lowest 'count' lanes set.
  function automatic logic [MAX_LANES-1:0] keep_mask(input logic [MASK_CNT_W-1:0] count);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      mask[i] = (MASK_CNT_W'(i) < count);
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_rd_tracker.sv
// Counts FIFO pops issued and bytes captured, and aligns the capture strobe
// with the FIFO read latency so the packer knows which lane to load.
module fifo_rd_tracker #(
  parameter int BYTES_PER_WORD = 4,
  parameter int RD_LATENCY     = 1,
  parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1),
  parameter int LANE_W         = $clog2(BYTES_PER_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              clear,
  output logic [CNT_W-1:0]  issued,
  output logic [CNT_W-1:0]  captured,
  output logic              cap_strobe,
  output logic [LANE_W-1:0] cap_lane
);

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign cap_strobe = rd_en;
    end else begin : g_lat1
      // Read data shows up one cycle after the pop edge.
      logic pend;
      always_ff @(posedge clk) begin
        if (!rst || clear) pend <= 1'b0;
        else               pend <= rd_en;
      end
      assign cap_strobe = pend;
    end
  endgenerate

  assign cap_lane = captured[LANE_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      issued   <= '0;
      captured <= '0;
    end else begin
      if (rd_en)      issued   <= issued + CNT_W'(1);
      if (cap_strobe) captured <= captured + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from the 8-bit FIFO and packs them LSB-first into wide words,
// with flush support for emitting a partial word under a keep mask.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int BYTES_PER_WORD = 4,
  parameter int RD_LATENCY     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_W-1:0]                fifo_data_out,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_W*BYTES_PER_WORD-1:0] word_out,
  output logic [BYTES_PER_WORD-1:0]        word_keep,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic                             busy
);

  localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_WORD);

  pack_state_t                            state;
  logic                                   flush_pending;
  logic [BYTES_PER_WORD-1:0][DATA_W-1:0]  lanes;
  logic [CNT_W-1:0]                       issued;
  logic [CNT_W-1:0]                       captured;
  logic [CNT_W-1:0]                       cap_next;
  logic                                   cap_strobe;
  logic                                   accept;
  logic [LANE_W-1:0]                      cap_lane;

  assign fifo_rd_en = rst && (state == FILL) && !fifo_empty &&
                      (issued < FULL_CNT) && !flush_pending;
  assign accept     = (state == OUT) && word_valid && word_ready;
  assign cap_next   = captured + CNT_W'(cap_strobe);
  assign busy       = (captured != '0) || (issued != captured) || word_valid;
  assign word_out   = lanes;

  fifo_rd_tracker #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .RD_LATENCY     (RD_LATENCY),
    .CNT_W          (CNT_W),
    .LANE_W         (LANE_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (fifo_rd_en),
    .clear      (accept),
    .issued     (issued),
    .captured   (captured),
    .cap_strobe (cap_strobe),
    .cap_lane   (cap_lane)
  );

  // Decisions use cap_next so a byte landing this edge counts toward completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= FILL;
      flush_pending <= 1'b0;
      lanes         <= '0;
      word_keep     <= '0;
      word_valid    <= 1'b0;
    end else begin
      if (cap_strobe) lanes[cap_lane] <= fifo_data_out;
      case (state)
        FILL: begin
          if (cap_next == FULL_CNT) begin
            state         <= OUT;
            word_keep     <= '1;
            word_valid    <= 1'b1;
            flush_pending <= 1'b0;
          end else if (flush_pending) begin
            if (issued != cap_next) begin
              state <= DRAIN;
            end else if (cap_next != '0) begin
              state         <= OUT;
              word_keep     <= BYTES_PER_WORD'(keep_mask(MASK_CNT_W'(cap_next)));
              word_valid    <= 1'b1;
              flush_pending <= 1'b0;
            end else begin
              flush_pending <= 1'b0;
            end
          end else if (flush) begin
            flush_pending <= 1'b1;
          end
        end
        DRAIN: begin
          if (issued == cap_next) begin
            flush_pending <= 1'b0;
            if (cap_next != '0) begin
              state      <= OUT;
              word_keep  <= BYTES_PER_WORD'(keep_mask(MASK_CNT_W'(cap_next)));
              word_valid <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        OUT: begin
          // A flush seen here is held and applied to the following word.
          if (flush) flush_pending <= 1'b1;
          if (word_ready) begin
            state      <= FILL;
            word_valid <= 1'b0;
            word_keep  <= '0;
            lanes      <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-based FIFO feeds the packer and a
// byte-stream model predicts every emitted word and keep mask.
module tb_fifo_word_packer;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  keep;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_data_out;
  logic        fifo_rd_en;
  logic        flush;
  logic [31:0] word_out;
  logic [3:0]  word_keep;
  logic        word_valid;
  logic        word_ready;
  logic        busy;

  logic [7:0]  fifo_q[$];
  logic [7:0]  model_bytes[$];
  exp_t        exp_words[$];
  exp_t        got;

  int          assert_count = 0;
  int          fail_count   = 0;
  int          pop_count    = 0;
  int          pop_base;
  logic        held = 1'b0;
  logic        accepted_prev = 1'b0;
  logic [31:0] held_word;
  logic [3:0]  held_keep;

  fifo_word_packer dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .word_out      (word_out),
    .word_keep     (word_keep),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous FIFO with one cycle of read latency.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_data_out <= fifo_q.pop_front();
      fifo_empty    <= (fifo_q.size() == 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Take n bytes from the head of the stream as one word, first byte in lane 0.
  task automatic model_emit(input int n);
    exp_t e;
    e.word = '0;
    for (int i = 0; i < n; i++) e.word = e.word | (32'(model_bytes.pop_front()) << (8 * i));
    e.keep = 4'((1 << n) - 1);
    exp_words.push_back(e);
  endtask

  task automatic model_flush();
    if (model_bytes.size() > 0) model_emit(model_bytes.size());
  endtask

  task automatic model_reset();
    model_bytes.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    model_bytes.push_back(b);
    if (model_bytes.size() == 4) model_emit(4);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_flush();
    step(1);
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_words.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    checkOutput(tag, 64'(exp_words.size()), '0);
  endtask

  // Cycle monitor: protocol rules plus scoreboard comparison on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      held          = 1'b0;
      accepted_prev = 1'b0;
    end else begin
      if (fifo_rd_en) pop_count++;
      if (fifo_empty) checkOutput("pop_while_empty", 64'(fifo_rd_en), '0);
      if (word_valid) checkOutput("pop_in_out", 64'(fifo_rd_en), '0);
      if (accepted_prev) checkOutput("valid_falls", 64'(word_valid), '0);
      if (held) begin
        checkOutput("hold_valid", 64'(word_valid), 64'(1));
        checkOutput("hold_word", 64'(word_out), 64'(held_word));
        checkOutput("hold_keep", 64'(word_keep), 64'(held_keep));
      end
      held          = word_valid && !word_ready;
      held_word     = word_out;
      held_keep     = word_keep;
      accepted_prev = word_valid && word_ready;
      if (word_valid && word_ready) begin
        if (exp_words.size() == 0) begin
          checkOutput("unexpected_word", 64'({1'b1, word_keep, word_out}), '0);
        end else begin
          got = exp_words.pop_front();
          checkOutput("word_data", 64'(word_out), 64'(got.word));
          checkOutput("word_keep", 64'(word_keep), 64'(got.keep));
        end
      end
    end
  end

  initial begin
    rst           = 1'b0;
    flush         = 1'b0;
    word_ready    = 1'b0;
    fifo_empty    = 1'b1;
    fifo_data_out = '0;

    // Reset with a non-empty FIFO; those bytes become the basic-pack word.
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    step(1);
    for (int c = 0; c < 2; c++) begin
      checkOutput("rst_rd_en", 64'(fifo_rd_en), '0);
      checkOutput("rst_valid", 64'(word_valid), '0);
      checkOutput("rst_busy", 64'(busy), '0);
      checkOutput("rst_keep", 64'(word_keep), '0);
      checkOutput("rst_word", 64'(word_out), '0);
      step(1);
    end
    rst        = 1'b1;
    word_ready = 1'b1;
    pop_base   = pop_count;
    wait_drain("basic_drain", 50);
    step(2);
    checkOutput("basic_pops", 64'(pop_count - pop_base), 64'(4));

    // Backpressure: first word held, remaining bytes stay in the FIFO.
    $display("[TB] backpressure");
    word_ready = 1'b0;
    for (int b = 1; b <= 8; b++) applyStimulus(8'(b));
    step(10);
    checkOutput("bp_valid", 64'(word_valid), 64'(1));
    checkOutput("bp_word", 64'(word_out), 64'(32'h04030201));
    checkOutput("bp_fifo_level", 64'(fifo_q.size()), 64'(4));
    word_ready = 1'b1;
    wait_drain("bp_drain", 50);
    step(2);

    // Partial flush followed by an empty flush.
    $display("[TB] partial flush");
    applyStimulus(8'hA1);
    applyStimulus(8'hB2);
    step(5);
    checkOutput("partial_busy", 64'(busy), 64'(1));
    pulse_flush();
    wait_drain("partial_drain", 30);
    step(3);
    checkOutput("partial_idle", 64'(busy), '0);
    pulse_flush();
    step(10);
    checkOutput("empty_flush_busy", 64'(busy), '0);
    checkOutput("empty_flush_valid", 64'(word_valid), '0);

    // Flush raised during the fourth pop must not produce an extra word.
    $display("[TB] flush race");
    pop_base = pop_count;
    applyStimulus(8'hC1);
    applyStimulus(8'hC2);
    applyStimulus(8'hC3);
    applyStimulus(8'hC4);
    step(3);
    checkOutput("race_align_pop", 64'(fifo_rd_en), 64'(1));
    checkOutput("race_align_cnt", 64'(pop_count - pop_base), 64'(3));
    pulse_flush();
    wait_drain("race_drain", 30);
    step(10);
    checkOutput("race_idle", 64'(busy), '0);

    // Reset with two bytes captured; they are discarded.
    $display("[TB] mid-word reset");
    applyStimulus(8'h99);
    applyStimulus(8'h9A);
    step(4);
    checkOutput("mid_busy", 64'(busy), 64'(1));
    rst = 1'b0;
    model_reset();
    step(1);
    checkOutput("mid_rst_busy", 64'(busy), '0);
    checkOutput("mid_rst_word", 64'(word_out), '0);
    rst = 1'b1;
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    wait_drain("mid_drain", 50);
    step(2);

    // Random traffic with random backpressure, closed by a flush.
    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 12) applyStimulus(8'($urandom));
      word_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    word_ready = 1'b1;
    for (int n = 0; n < 200 && fifo_q.size() != 0; n++) step(1);
    checkOutput("rand_fifo_drained", 64'(fifo_q.size()), '0);
    wait_drain("rand_drain", 200);
    step(4);
    pulse_flush();
    wait_drain("rand_tail", 50);
    step(5);
    checkOutput("final_busy", 64'(busy), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the 8-bit synchronous FIFO. It pops bytes from the FIFO read port and packs BYTES_PER_WORD consecutive bytes into one wide word. The first byte popped goes in the least-significant lane. Completed words go out on a valid/ready interface toward the bus/DMA stage. A flush request emits a partial word with a lane-keep mask.

Parameters:
DATA_W, 8, FIFO byte width; must match the FIFO data width.
BYTES_PER_WORD, 4, bytes packed per output word (2..8).
RD_LATENCY, 1, cycles from sampled fifo_rd_en to valid fifo_data_out; legal values 0 or 1.

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
fifo_empty  input  1  FIFO empty flag
fifo_data_out  input  DATA_W  FIFO read data
fifo_rd_en  output  1  FIFO pop request
flush  input  1  single-cycle request to emit the pending partial word
word_out  output  DATA_W*BYTES_PER_WORD  packed word, byte 0 in [DATA_W-1:0]
word_keep  output  BYTES_PER_WORD  per-lane valid mask for word_out
word_valid  output  1  word_out/word_keep valid
word_ready  input  1  downstream accept
busy  output  1  high when any byte is captured, in flight, or held

Behaviour:
- Reset (rst=0 at a rising edge): state=FILL, all counters 0, word_out=0, word_keep=0, word_valid=0, busy=0. fifo_rd_en is forced 0 during reset.
- A reset mid-packing discards any partial word and in-flight read. A byte popped in that window is lost; this is intended.
- States: FILL, DRAIN, OUT.
- FILL:
  - fifo_rd_en = !fifo_empty && (issued < BYTES_PER_WORD) && !flush_pending. This is combinational.
  - fifo_rd_en is never 1 while fifo_empty=1.
  - Back-to-back pops are allowed, one byte per cycle.
  - issued counts pops; captured counts bytes written into lanes.
  - With RD_LATENCY=1, fifo_data_out is captured into lane[captured] one cycle after the pop edge.
  - With RD_LATENCY=0, capture happens on the pop edge itself.
- Word complete: when captured reaches BYTES_PER_WORD, go to OUT with word_keep all ones and word_valid=1 on the next cycle.
- Flush:
  - A flush pulse sets flush_pending, which blocks new pops.
  - If pops are in flight, go to DRAIN and wait until captured == issued.
  - Then, if captured>0, go to OUT with word_keep = (1<<captured)-1 and unfilled lanes zero.
  - If captured==0, clear flush_pending and stay in FILL with no output.
  - flush while in OUT is remembered (flush_pending) and applies to the next word.
  - flush coinciding with the final byte capture yields a full word, and flush_pending clears.
- OUT:
  - word_out, word_keep and word_valid stay stable until word_ready=1 while word_valid=1.
  - On that handshake edge: counters clear, lanes clear, go to FILL.
  - word_valid falls the cycle after acceptance unless reset intervenes.
  - No pops are issued in OUT, so downstream backpressure propagates to the FIFO, which then fills and asserts full.
- Throughput: full words complete every BYTES_PER_WORD+RD_LATENCY+1 cycles minimum when the FIFO never empties and word_ready is held high.
- FIFO empty mid-word: pops stall and captured lanes are held indefinitely. No timeout.
- busy = (captured!=0) || (issued!=captured) || word_valid.
- Counter width is clog2(BYTES_PER_WORD+1); counters never wrap.

Decomposition:
- Shared package fifo_pkg: DATA_W default, the state enumeration (FILL, DRAIN, OUT), and the keep-mask function that maps a count to a mask.
- One sub-module is natural: fifo_rd_tracker. It holds the issued/captured counters and the RD_LATENCY capture pipe, and outputs the capture strobe plus the lane index.
- The FSM and lane registers stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with FIFO non-empty -> fifo_rd_en=0, word_valid=0, busy=0 throughout.
- Basic pack: push 0x11,0x22,0x33,0x44 into the FIFO, word_ready=1 -> word_out=0x44332211, word_keep=4'b1111, exactly 4 fifo_rd_en pulses, never with fifo_empty=1.
- Backpressure: push 8 bytes 0x01..0x08 and hold word_ready=0 for 10 cycles:
  - word_out=0x04030201 is held stable with no further pops during the stall.
  - After release, the second word is 0x08070605.
- Partial flush: push 0xA1,0xB2, wait until busy settles, pulse flush -> word_out=0x0000B2A1, word_keep=4'b0011; an empty flush afterwards produces no word.
- Flush race: pulse flush in the same cycle as the 4th byte pop -> one full word with keep=4'b1111 and no extra empty word.
- Mid-word reset: after 2 bytes are captured, assert rst=0 for 1 cycle, then push 0x55,0x66,0x77,0x88 -> word_out=0x88776655 with no stale lanes.
